// File: rtl/vram_arbiter.sv
// Single-port video/font memory arbiter: scan-out has absolute priority, the CPU
// port gets the free slots through a posted-write buffer and an IDLE/RD/ACK FSM.
module vram_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int WB_DEPTH   = 2,
  parameter int STARVE_MAX = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  // scan-out port
  input  logic                      v_req,
  input  logic [AW-1:0]             v_address,
  output logic [DW-1:0]             v_data,
  // CPU port
  input  logic                      c_req,
  input  logic                      c_we,
  input  logic [AW-1:0]             c_address,
  input  logic [DW-1:0]             c_wdata,
  output logic                      c_ack,
  output logic [DW-1:0]             c_rdata,
  // memory port
  output logic [AW-1:0]             m_address,
  output logic [DW-1:0]             m_wdata,
  output logic                      m_we,
  input  logic [DW-1:0]             m_data,
  // status and debug
  output logic                      overrun,
  output logic [1:0]                dbg_state,
  output logic [$clog2(WB_DEPTH):0] dbg_wb_count
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state, state_next;

  logic [AW-1:0] wb_addr [WB_DEPTH];
  logic [DW-1:0] wb_data [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          wb_empty, wb_full;
  logic          push, pop, rd_accept, accept, starve_inc;
  logic [SW-1:0] starve_cnt, starve_next;

  // CPU handshake: c_req is held with stable command fields until the single-cycle
  // c_ack pulse; a request is taken only in IDLE, so c_req during ACK never re-issues.
  assign wb_empty  = (count == '0);
  assign wb_full   = (count == CW'(WB_DEPTH));
  assign push      = (state == IDLE) && c_req && c_we && !wb_full;
  assign rd_accept = (state == IDLE) && c_req && !c_we && wb_empty && !v_req;
  assign pop       = !v_req && !wb_empty;
  assign accept    = push || rd_accept;
  assign starve_inc = (state == IDLE) && c_req && !accept && v_req;

  assign v_data       = m_data;
  assign c_ack        = (state == ACK);
  assign dbg_state    = state;
  assign dbg_wb_count = count;

  // Slot owner: video, then buffer drain, then a CPU read; idle slots park on video.
  always_comb begin
    m_address = v_address;
    m_wdata   = '0;
    m_we      = 1'b0;
    if (!v_req) begin
      if (!wb_empty) begin
        m_address = wb_addr[head];
        m_wdata   = wb_data[head];
        m_we      = 1'b1;
      end else if (rd_accept) begin
        m_address = c_address;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push)           state_next = ACK;
        else if (rd_accept) state_next = RD;
      end
      RD:      state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (accept || !c_req)
      starve_next = '0;
    else if (starve_inc && (starve_cnt != SW'(STARVE_MAX)))
      starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      c_rdata    <= '0;
      starve_cnt <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // In RD, m_data holds the word addressed on the acceptance cycle.
      if (state == RD) c_rdata <= m_data;
      starve_cnt <= starve_next;
      if (starve_next == SW'(STARVE_MAX)) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      wb_addr[tail] <= c_address;
      wb_data[tail] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, video reads, posted writes, ordered reads,
// starvation flag and mid-operation reset, against a registered-read memory model.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          v_req;
  logic [AW-1:0] v_address;
  logic [DW-1:0] v_data;
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_data;
  logic          overrun;
  logic [1:0]    dbg_state;
  logic [1:0]    dbg_wb_count;

  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [8192];

  int n_checks = 0;
  int n_pass   = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .WB_DEPTH(2), .STARVE_MAX(16)) dut (
    .clock(clock), .reset(reset),
    .v_req(v_req), .v_address(v_address), .v_data(v_data),
    .c_req(c_req), .c_we(c_we), .c_address(c_address), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .m_address(m_address), .m_wdata(m_wdata), .m_we(m_we), .m_data(m_data),
    .overrun(overrun), .dbg_state(dbg_state), .dbg_wb_count(dbg_wb_count)
  );

  always #5 clock = ~clock;

  // Memory model: registered read, write on m_we; pl_* is a bench-side preload port.
  always @(posedge clock) begin
    if (pl_we)     mem[pl_addr]   <= pl_data;
    else if (m_we) mem[m_address] <= m_wdata;
    m_data <= mem[m_address];
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc();
    pl_we = 1'b1; pl_addr = a; pl_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; v_req = 1'b0; v_address = '0;
    c_req = 1'b0; c_we = 1'b0; c_address = '0; c_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) cyc();
    reset = 1'b0;
    #2;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL reset_c_ack got %0h exp 0", c_ack); else n_pass++;
    n_checks++; if (c_rdata !== 8'h00) $display("FAIL reset_c_rdata got %0h exp 0", c_rdata); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %0h exp 0", overrun); else n_pass++;
    n_checks++; if (dbg_wb_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", dbg_wb_count); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    n_checks++; if (m_we !== 1'b0) $display("FAIL reset_m_we got %0h exp 0", m_we); else n_pass++;
    preload(13'h1000, 8'h41);
    preload(13'h0041, 8'h5C);
    preload(13'h0042, 8'h77);
    preload(13'h0100, 8'h00);
    preload(13'h0200, 8'h00);
    preload(13'h0201, 8'h00);
    cyc();
    pl_we = 1'b0;
  endtask

  task automatic test_video();
    cyc();
    v_req = 1'b1; v_address = 13'h1000;
    #2;
    n_checks++; if (m_address !== 13'h1000) $display("FAIL video_m_address got %0h exp 1000", m_address); else n_pass++;
    n_checks++; if (m_we !== 1'b0) $display("FAIL video_m_we got %0h exp 0", m_we); else n_pass++;
    cyc();
    #2;
    n_checks++; if (v_data !== 8'h41) $display("FAIL video_v_data got %0h exp 41", v_data); else n_pass++;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL video_c_ack got %0h exp 0", c_ack); else n_pass++;
  endtask

  task automatic test_write_under_video();
    cyc();
    c_req = 1'b1; c_we = 1'b1; c_address = 13'h1A02; c_wdata = 8'h1F;
    #2;
    n_checks++; if (m_we !== 1'b0) $display("FAIL wv_m_we_c0 got %0h exp 0", m_we); else n_pass++;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL wv_ack_c0 got %0h exp 0", c_ack); else n_pass++;
    cyc();
    c_req = 1'b0;
    #2;
    n_checks++; if (c_ack !== 1'b1) $display("FAIL wv_ack_c1 got %0h exp 1", c_ack); else n_pass++;
    n_checks++; if (m_we !== 1'b0) $display("FAIL wv_m_we_c1 got %0h exp 0", m_we); else n_pass++;
    cyc();
    v_req = 1'b0;
    #2;
    n_checks++; if (m_we !== 1'b1) $display("FAIL wv_drain_we got %0h exp 1", m_we); else n_pass++;
    n_checks++; if (m_address !== 13'h1A02) $display("FAIL wv_drain_addr got %0h exp 1a02", m_address); else n_pass++;
    n_checks++; if (m_wdata !== 8'h1F) $display("FAIL wv_drain_data got %0h exp 1f", m_wdata); else n_pass++;
    cyc();
    v_req = 1'b1;
    #2;
    n_checks++; if (m_we !== 1'b0) $display("FAIL wv_m_we_after got %0h exp 0", m_we); else n_pass++;
    n_checks++; if (dbg_wb_count !== 2'd0) $display("FAIL wv_count got %0d exp 0", dbg_wb_count); else n_pass++;
    n_checks++; if (mem[13'h1A02] !== 8'h1F) $display("FAIL wv_mem got %0h exp 1f", mem[13'h1A02]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]    vpat;
    logic [DW-1:0] exp_wd;
    logic          exp_ack, exp_we;
    vpat = 8'b0000_0111;
    for (int c = 0; c <= 10; c++) begin
      cyc();
      v_req = vpat[(c + 7) % 8];
      if (c < 2)       begin c_req = 1'b1; c_we = 1'b1; c_address = 13'h0100; c_wdata = 8'hA1; end
      else if (c < 4)  begin c_req = 1'b1; c_we = 1'b1; c_address = 13'h0101; c_wdata = 8'hB2; end
      else if (c < 7)  begin c_req = 1'b1; c_we = 1'b1; c_address = 13'h0102; c_wdata = 8'hC3; end
      else if (c < 10) begin c_req = 1'b1; c_we = 1'b0; c_address = 13'h0100; c_wdata = 8'h00; end
      else             begin c_req = 1'b0; c_we = 1'b0; end
      #2;
      exp_ack = (c == 1) || (c == 3) || (c == 6) || (c == 9);
      exp_we  = (c >= 4) && (c <= 6);
      n_checks++; if (c_ack !== exp_ack) $display("FAIL b2b_ack_c%0d got %0h exp %0h", c, c_ack, exp_ack); else n_pass++;
      n_checks++; if (m_we !== exp_we) $display("FAIL b2b_we_c%0d got %0h exp %0h", c, m_we, exp_we); else n_pass++;
      if (exp_we) begin
        exp_wd = (c == 4) ? 8'hA1 : (c == 5) ? 8'hB2 : 8'hC3;
        n_checks++; if (m_address !== 13'(13'h0100 + c - 4)) $display("FAIL b2b_addr_c%0d got %0h exp %0h", c, m_address, 13'(13'h0100 + c - 4)); else n_pass++;
        n_checks++; if (m_wdata !== exp_wd) $display("FAIL b2b_wdata_c%0d got %0h exp %0h", c, m_wdata, exp_wd); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (dbg_wb_count !== 2'd2) $display("FAIL b2b_full_count got %0d exp 2", dbg_wb_count); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL b2b_stall_state got %0d exp 0", dbg_state); else n_pass++;
      end
      if (c == 7) begin
        n_checks++; if (m_address !== 13'h0100) $display("FAIL b2b_rd_addr got %0h exp 0100", m_address); else n_pass++;
      end
      if (c == 9) begin
        n_checks++; if (c_rdata !== 8'hA1) $display("FAIL b2b_rdata got %0h exp a1", c_rdata); else n_pass++;
      end
    end
    n_checks++; if (mem[13'h0101] !== 8'hB2) $display("FAIL b2b_mem101 got %0h exp b2", mem[13'h0101]); else n_pass++;
  endtask

  task automatic test_read();
    cyc();
    v_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_address = 13'h0041;
    #2;
    n_checks++; if (m_address !== 13'h0041) $display("FAIL rd_m_address got %0h exp 0041", m_address); else n_pass++;
    n_checks++; if (m_we !== 1'b0) $display("FAIL rd_m_we got %0h exp 0", m_we); else n_pass++;
    cyc();
    #2;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL rd_ack_c1 got %0h exp 0", c_ack); else n_pass++;
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL rd_state_c1 got %0d exp 1", dbg_state); else n_pass++;
    cyc();
    #2;
    n_checks++; if (c_ack !== 1'b1) $display("FAIL rd_ack_c2 got %0h exp 1", c_ack); else n_pass++;
    n_checks++; if (c_rdata !== 8'h5C) $display("FAIL rd_rdata got %0h exp 5c", c_rdata); else n_pass++;
    cyc();
    c_req = 1'b0;
    #2;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rd_no_reaccept got %0d exp 0", dbg_state); else n_pass++;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL rd_ack_c3 got %0h exp 0", c_ack); else n_pass++;
    cyc();
    #2;
    n_checks++; if (c_ack !== 1'b0) $display("FAIL rd_ack_c4 got %0h exp 0", c_ack); else n_pass++;
  endtask

  task automatic test_starve();
    for (int c = 0; c < 20; c++) begin
      cyc();
      v_req = 1'b1; v_address = 13'h1000;
      c_req = 1'b1; c_we = 1'b0; c_address = 13'h0042;
      #2;
      if (c == 15) begin
        n_checks++; if (overrun !== 1'b0) $display("FAIL starve_c15 got %0h exp 0", overrun); else n_pass++;
      end
      if (c == 16) begin
        n_checks++; if (overrun !== 1'b1) $display("FAIL starve_c16 got %0h exp 1", overrun); else n_pass++;
      end
      if (c == 19) begin
        n_checks++; if (c_ack !== 1'b0) $display("FAIL starve_ack_c19 got %0h exp 0", c_ack); else n_pass++;
      end
    end
    cyc();
    v_req = 1'b0;
    #2;
    n_checks++; if (m_address !== 13'h0042) $display("FAIL starve_rd_addr got %0h exp 0042", m_address); else n_pass++;
    cyc();
    v_req = 1'b1;
    cyc();
    c_req = 1'b0;
    #2;
    n_checks++; if (c_ack !== 1'b1) $display("FAIL starve_ack got %0h exp 1", c_ack); else n_pass++;
    n_checks++; if (c_rdata !== 8'h77) $display("FAIL starve_rdata got %0h exp 77", c_rdata); else n_pass++;
    cyc();
    v_req = 1'b0;
    #2;
    n_checks++; if (overrun !== 1'b1) $display("FAIL starve_sticky got %0h exp 1", overrun); else n_pass++;
  endtask

  task automatic test_reset_midop();
    cyc();
    v_req = 1'b1; c_req = 1'b1; c_we = 1'b1; c_address = 13'h0200; c_wdata = 8'h11;
    cyc();
    c_req = 1'b0;
    #2;
    n_checks++; if (c_ack !== 1'b1) $display("FAIL rst_w1_ack got %0h exp 1", c_ack); else n_pass++;
    cyc();
    c_req = 1'b1; c_address = 13'h0201; c_wdata = 8'h22;
    cyc();
    c_req = 1'b0;
    cyc();
    reset = 1'b1;
    #2;
    n_checks++; if (dbg_wb_count !== 2'd2) $display("FAIL rst_pre_count got %0d exp 2", dbg_wb_count); else n_pass++;
    cyc();
    reset = 1'b0; v_req = 1'b0;
    #2;
    n_checks++; if (dbg_wb_count !== 2'd0) $display("FAIL rst_count got %0d exp 0", dbg_wb_count); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %0h exp 0", overrun); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        cyc();
        #2;
      end
      n_checks++; if (m_we !== 1'b0) $display("FAIL rst_m_we_c%0d got %0h exp 0", c, m_we); else n_pass++;
      n_checks++; if (c_ack !== 1'b0) $display("FAIL rst_ack_c%0d got %0h exp 0", c, c_ack); else n_pass++;
    end
    n_checks++; if (mem[13'h0200] !== 8'h00) $display("FAIL rst_mem200 got %0h exp 0", mem[13'h0200]); else n_pass++;
    n_checks++; if (mem[13'h0201] !== 8'h00) $display("FAIL rst_mem201 got %0h exp 0", mem[13'h0201]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_video();
    test_write_under_video();
    test_back_to_back();
    test_read();
    test_starve();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
